// File: rtl/microsequencer.sv
// ---------------------------------------------------------------------------
// microsequencer
//
// Steps the CPU through its microcode T-states. T0 and T1 issue the fixed
// fetch microinstructions; T2..T7 issue the word read from the microcode ROM
// at {opcode, tstate}. The sequencer latches the ALU flags on EO cycles and
// turns the jump bits of the current microinstruction into a PC-load strobe.
//
// Optional feature: define SEQ_WAIT_EN to enable device wait states. Without
// it, stall is tied low and dev_busy is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   opcode     IR high byte, stable from T2 onward
//   rom_addr   microcode ROM address {opcode, tstate}
//   rom_data   microcode ROM data (asynchronous read)
//   alu_c/z/n  live ALU carry / zero / negative
//   dev_busy   device not ready (only with SEQ_WAIT_EN)
//   uinstr     current microinstruction, to the control decoder
//   tstate     current T-state
//   flags      latched flags {C,Z,N}
//   pc_load    jump taken in the current microinstruction
//   stall      wait state in progress
// ---------------------------------------------------------------------------
module microsequencer #(
    parameter logic [15:0] FETCH0 = 16'h0040,
    parameter logic [15:0] FETCH1 = 16'h3480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  opcode,
    output logic [10:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        dev_busy,
    output logic [15:0] uinstr,
    output logic [2:0]  tstate,
    output logic [2:0]  flags,
    output logic        pc_load,
    output logic        stall
);

    logic [2:0] tstate_reg;
    logic [2:0] tstate_next;
    logic [2:0] flags_reg;
    logic [2:0] flags_next;

    logic eo;
    logic rt;

`ifndef SEQ_WAIT_EN
    // dev_busy has no function without wait states.
    logic unused_dev_busy;
    assign unused_dev_busy = dev_busy;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tstate_reg <= 3'd0;
            flags_reg  <= 3'd0;
        end else begin
            tstate_reg <= tstate_next;
            flags_reg  <= flags_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        tstate_next = tstate_reg;
        flags_next  = flags_reg;
        if (!stall) begin
            // Natural 3-bit overflow gives the T7 -> T0 wrap.
            tstate_next = rt ? 3'd0 : tstate_reg + 3'd1;
            if (eo) begin
                flags_next = {alu_c, alu_z, alu_n};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        case (tstate_reg)
            3'd0:    uinstr = FETCH0;
            3'd1:    uinstr = FETCH1;
            default: uinstr = rom_data;
        endcase

        eo = uinstr[15];
        // RT only matters once the ROM drives uinstr; the fetch words never
        // carry it, but the T-state qualifier keeps a bad parameter harmless.
        rt = !eo && uinstr[11] && (tstate_reg > 3'd1);

`ifdef SEQ_WAIT_EN
        // bus_out (14:12) only means a source when EO is clear.
        stall = dev_busy && ((!eo && (uinstr[14:12] == 3'd6)) ||
                             (uinstr[8:6] == 3'd6));
`else
        stall = 1'b0;
`endif

        // Jumps evaluate against the latched flags {C,Z,N}, never the live
        // ALU outputs, so an EO+jump word sees the previous flags.
        pc_load = !stall &&
                  ((uinstr[5] && flags_reg[2]) ||
                   (uinstr[4] && flags_reg[1]) ||
                   (uinstr[3] && !flags_reg[1] && !flags_reg[0]) ||
                   (uinstr[2] && flags_reg[0]));
    end

    assign rom_addr = {opcode, tstate_reg};
    assign tstate   = tstate_reg;
    assign flags    = flags_reg;

endmodule
